// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   PS2_EXT / PS2_BRK  - prefix bytes for extended keys and key releases
//   ps2_evt_t          - one decoded key event, also the event FIFO word
//   odd_parity_ok()    - frame parity check (data + parity has odd ones)
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;   // byte was preceded by E0
    logic       brk;   // byte was preceded by F0 (key release)
    logic [7:0] code;  // scan code
  } ps2_evt_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Bit-level PS/2 deframer. Synchronises the raw PS/2 lines, samples data on
// each ps2_clk falling edge, assembles 11-bit frames and checks start,
// parity and stop. A stalled partial frame is discarded after TIMEOUT_CYC
// clk cycles without a falling edge.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   ps2_clk      - raw PS/2 clock (asynchronous)
//   ps2_data     - raw PS/2 data (asynchronous)
//   byte_valid   - one-cycle pulse, rx_byte holds a good frame's data
//   rx_byte      - received data byte
//   frame_err    - one-cycle pulse, the frame just completed was rejected
// Both pulses occur the cycle after the stop-bit edge is detected.
// ---------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   start_bad_q, start_bad_d;
  logic                   par_q, par_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [7:0]             byte_q, byte_d;

  logic fall;
  logic din;

  always_comb begin
    // Synchroniser chains shift in from bit 0; the last stage is the clean copy.
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];

    fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    din  = data_sync_q[SYNC_STAGES-1];

    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    start_bad_d  = start_bad_q;
    par_d        = par_q;
    tmo_cnt_d    = tmo_cnt_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_d       = byte_q;

    if (fall) begin
      tmo_cnt_d = '0;
      case (bit_cnt_q)
        4'd0:    start_bad_d = din;
        4'd9:    par_d       = din;
        4'd10: begin
          // Stop bit: the whole frame is judged here, all-or-nothing.
          if (!start_bad_q && odd_parity_ok(shift_q, par_q) && din) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
        default: shift_d = {din, shift_q[7:1]};  // data arrives LSB first
      endcase
      bit_cnt_d = (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (bit_cnt_q != 4'd0) begin
      // Mid-frame with a quiet clock line: abandon the frame once stalled.
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q   <= '0;
      data_sync_q  <= '0;
      clk_prev_q   <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      start_bad_q  <= 1'b0;
      par_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_q       <= 8'h00;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      start_bad_q  <= start_bad_d;
      par_q        <= par_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      byte_q       <= byte_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver: deframes bytes (ps2_frame_rx), folds E0/F0
// prefixes into single key events, buffers them in a first-word
// fall-through FIFO and keeps typematic-aware key press statistics.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   ps2_clk, ps2_data   - raw PS/2 lines (asynchronous, input only)
//   out_ready           - consumer takes the head event
//   out_valid           - FIFO non-empty
//   out_code/ext/break  - head event fields (0 when empty)
//   key_count           - number of new key presses, wraps
//   key_held            - a key is currently held
//   cur_code/cur_ext    - last make event
//   parity_err          - one-cycle pulse on a rejected frame
//   overflow            - sticky, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_code,
  output logic             out_ext,
  output logic             out_break,
  output logic [CNT_W-1:0] key_count,
  output logic             key_held,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic             parity_err,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit tells full from empty

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  // ---------------- decoder ----------------
  logic     ext_pend_q, ext_pend_d;
  logic     brk_pend_q, brk_pend_d;
  logic     evt_push;
  ps2_evt_t evt;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    evt_push   = 1'b0;
    evt        = '{ext: ext_pend_q, brk: brk_pend_q, code: rx_byte};
    if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        evt_push   = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // ---------------- event FIFO ----------------
  ps2_evt_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            fifo_empty, fifo_full, pop, push_ok;
  ps2_evt_t        head;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    push_ok    = evt_push && (!fifo_full || pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q || (evt_push && !push_ok);
    head       = mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: the storage array has no reset; validity comes from the pointers,
  // and the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= evt;
    end
  end

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] key_count_q, key_count_d;
  logic             key_held_q, key_held_d;
  logic [7:0]       cur_code_q, cur_code_d;
  logic             cur_ext_q, cur_ext_d;
  logic             same_key;

  always_comb begin
    key_count_d = key_count_q;
    key_held_d  = key_held_q;
    cur_code_d  = cur_code_q;
    cur_ext_d   = cur_ext_q;
    same_key    = ({evt.ext, evt.code} == {cur_ext_q, cur_code_q});
    if (evt_push) begin
      if (!evt.brk) begin
        // A make of the key already held is an auto-repeat, not a new press.
        if (!key_held_q || !same_key) begin
          key_count_d = key_count_q + CNT_W'(1);
        end
        key_held_d = 1'b1;
        cur_code_d = evt.code;
        cur_ext_d  = evt.ext;
      end else if (same_key) begin
        key_held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      key_count_q <= '0;
      key_held_q  <= 1'b0;
      cur_code_q  <= 8'h00;
      cur_ext_q   <= 1'b0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      key_count_q <= key_count_d;
      key_held_q  <= key_held_d;
      cur_code_q  <= cur_code_d;
      cur_ext_q   <= cur_ext_d;
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_code   = fifo_empty ? 8'h00 : head.code;
  assign out_ext    = fifo_empty ? 1'b0  : head.ext;
  assign out_break  = fifo_empty ? 1'b0  : head.brk;
  assign key_count  = key_count_q;
  assign key_held   = key_held_q;
  assign cur_code   = cur_code_q;
  assign cur_ext    = cur_ext_q;
  assign parity_err = frame_err;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Self-checking bench for ps2_kbd_rx: a table of frames with expected
// events/statistics, hand sequences for overflow, timeout and mid-frame
// reset, and a randomized phase checked against a byte-level model.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH  = 8;
  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 3;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 6;   // clk cycles per PS/2 clock half period

  logic             clk = 1'b0;
  logic             rst;
  logic             ps2_clk;
  logic             ps2_data;
  logic             out_ready;
  logic             out_valid;
  logic [7:0]       out_code;
  logic             out_ext;
  logic             out_break;
  logic [CNT_W-1:0] key_count;
  logic             key_held;
  logic [7:0]       cur_code;
  logic             cur_ext;
  logic             parity_err;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .out_ext    (out_ext),
    .out_break  (out_break),
    .key_count  (key_count),
    .key_held   (key_held),
    .cur_code   (cur_code),
    .cur_ext    (cur_ext),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit 0, 3 start bit 1
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    if (kind == 3) f[0]  = 1'b1;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    wait_cyc(1);
    out_ready = 1'b0;
  endtask

  // parity_err high-cycle counter, sampled away from the active edge
  int pe_cycles = 0;
  always @(negedge clk) if (parity_err === 1'b1) pe_cycles++;

  // ---------------- reference model (byte level) ----------------
  ps2_evt_t exp_q[$];
  bit       m_ext_pend, m_brk_pend, m_held, m_ext;
  logic [7:0] m_code;
  int       m_count;

  task automatic model_byte(input logic [7:0] b);
    ps2_evt_t e;
    if (b == PS2_EXT) m_ext_pend = 1'b1;
    else if (b == PS2_BRK) m_brk_pend = 1'b1;
    else begin
      e = '{ext: m_ext_pend, brk: m_brk_pend, code: b};
      exp_q.push_back(e);
      if (!e.brk) begin
        if (!m_held || e.ext != m_ext || e.code != m_code) m_count++;
        m_held = 1'b1;
        m_code = e.code;
        m_ext  = e.ext;
      end else if (e.ext == m_ext && e.code == m_code) begin
        m_held = 1'b0;
      end
      m_ext_pend = 1'b0;
      m_brk_pend = 1'b0;
    end
  endtask

  bit mon_en   = 1'b0;
  bit rand_run = 1'b0;

  // consumer-side scoreboard for the randomized phase
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got %0h expected none", {out_ext, out_break, out_code});
      end else begin
        check("rand_evt", {out_ext, out_break, out_code}, exp_q.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_run) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] b;
    int         kind;
    bit         push;
    logic [9:0] evt;    // {ext, brk, code}
    int         cnt;
    bit         held;
    logic [7:0] cur;
    bit         cext;
  } vec_t;

  vec_t vecs[21];

  initial begin
    vecs[0]  = '{8'h1C, 0, 1'b1, 10'h01C, 1, 1'b1, 8'h1C, 1'b0};
    vecs[1]  = '{8'hF0, 0, 1'b0, 10'h000, 1, 1'b1, 8'h1C, 1'b0};
    vecs[2]  = '{8'h1C, 0, 1'b1, 10'h11C, 1, 1'b0, 8'h1C, 1'b0};
    vecs[3]  = '{8'hE0, 0, 1'b0, 10'h000, 1, 1'b0, 8'h1C, 1'b0};
    vecs[4]  = '{8'h75, 0, 1'b1, 10'h275, 2, 1'b1, 8'h75, 1'b1};
    vecs[5]  = '{8'hE0, 0, 1'b0, 10'h000, 2, 1'b1, 8'h75, 1'b1};
    vecs[6]  = '{8'hF0, 0, 1'b0, 10'h000, 2, 1'b1, 8'h75, 1'b1};
    vecs[7]  = '{8'h75, 0, 1'b1, 10'h375, 2, 1'b0, 8'h75, 1'b1};
    vecs[8]  = '{8'h1C, 0, 1'b1, 10'h01C, 3, 1'b1, 8'h1C, 1'b0};
    vecs[9]  = '{8'h1C, 0, 1'b1, 10'h01C, 3, 1'b1, 8'h1C, 1'b0};
    vecs[10] = '{8'h1C, 0, 1'b1, 10'h01C, 3, 1'b1, 8'h1C, 1'b0};
    vecs[11] = '{8'hF0, 0, 1'b0, 10'h000, 3, 1'b1, 8'h1C, 1'b0};
    vecs[12] = '{8'h1C, 0, 1'b1, 10'h11C, 3, 1'b0, 8'h1C, 1'b0};
    vecs[13] = '{8'h1C, 0, 1'b1, 10'h01C, 4, 1'b1, 8'h1C, 1'b0};
    vecs[14] = '{8'h1C, 1, 1'b0, 10'h000, 4, 1'b1, 8'h1C, 1'b0};
    vecs[15] = '{8'hF0, 2, 1'b0, 10'h000, 4, 1'b1, 8'h1C, 1'b0};
    vecs[16] = '{8'h1C, 0, 1'b1, 10'h01C, 4, 1'b1, 8'h1C, 1'b0};
    vecs[17] = '{8'hE0, 0, 1'b0, 10'h000, 4, 1'b1, 8'h1C, 1'b0};
    vecs[18] = '{8'h74, 3, 1'b0, 10'h000, 4, 1'b1, 8'h1C, 1'b0};
    vecs[19] = '{8'h74, 1, 1'b0, 10'h000, 4, 1'b1, 8'h1C, 1'b0};
    vecs[20] = '{8'h74, 0, 1'b1, 10'h274, 5, 1'b1, 8'h74, 1'b1};
  end

  initial begin
    int pe0;
    logic [7:0] b;
    int kind;

    rst       = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    out_ready = 1'b0;
    do_reset();

    // reset state
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_out_code",   out_code,   8'h00);
    check("rst_out_flags",  {out_ext, out_break}, 2'b00);
    check("rst_key_count",  key_count,  8'h00);
    check("rst_key_held",   key_held,   1'b0);
    check("rst_cur",        {cur_ext, cur_code}, 9'h000);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_overflow",   overflow,   1'b0);

    // directed table
    for (int i = 0; i < 21; i++) begin
      pe0 = pe_cycles;
      send_bits(frame_bits(vecs[i].b, vecs[i].kind), 11);
      check($sformatf("v%0d_parity_err_cycles", i), pe_cycles - pe0, (vecs[i].kind != 0) ? 1 : 0);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].push);
      if (vecs[i].push) begin
        check($sformatf("v%0d_evt", i), {out_ext, out_break, out_code}, vecs[i].evt);
        pop_one();
        check($sformatf("v%0d_drained", i), out_valid, 1'b0);
      end
      check($sformatf("v%0d_key_count", i), key_count, vecs[i].cnt);
      check($sformatf("v%0d_key_held", i), key_held, vecs[i].held);
      check($sformatf("v%0d_cur", i), {cur_ext, cur_code}, {vecs[i].cext, vecs[i].cur});
    end
    check("tbl_overflow", overflow, 1'b0);

    // overflow: 9 distinct makes into an 8-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_bits(frame_bits(8'h10 + 8'(i), 0), 11);
      if (i == 7) check("ovf_not_yet", overflow, 1'b0);
    end
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_key_count", key_count, 8'd9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_valid%0d", i), out_valid, 1'b1);
      check($sformatf("ovf_code%0d", i), {out_ext, out_break, out_code}, {2'b00, 8'h10 + 8'(i)});
      pop_one();
    end
    check("ovf_empty", out_valid, 1'b0);
    check("ovf_still_set", overflow, 1'b1);

    // timeout: partial frame, long idle, then a clean frame
    do_reset();
    send_bits(frame_bits(8'h5A, 0), 5);
    wait_cyc(TIMEOUT_CYC + 1);
    pe0 = pe_cycles;
    send_bits(frame_bits(8'h1C, 0), 11);
    check("tmo_no_err", pe_cycles - pe0, 0);
    check("tmo_valid", out_valid, 1'b1);
    check("tmo_evt", {out_ext, out_break, out_code}, 10'h01C);
    pop_one();

    // reset in the middle of a frame
    send_bits(frame_bits(8'h33, 0), 6);
    rst = 1'b1;
    wait_cyc(2);
    check("midrst_during_count", key_count, 8'h00);
    rst = 1'b0;
    wait_cyc(1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_stats", {key_held, cur_ext, cur_code}, 10'h000);
    check("midrst_overflow", overflow, 1'b0);
    pe0 = pe_cycles;
    send_bits(frame_bits(8'h1C, 0), 11);
    check("midrst_no_err", pe_cycles - pe0, 0);
    check("midrst_evt", {out_valid, out_ext, out_break, out_code}, 11'h41C);
    check("midrst_key_count", key_count, 8'd1);
    pop_one();

    // randomized phase against the byte-level model
    do_reset();
    m_ext_pend = 1'b0; m_brk_pend = 1'b0; m_held = 1'b0;
    m_ext = 1'b0; m_code = 8'h00; m_count = 0;
    exp_q.delete();
    mon_en   = 1'b1;
    rand_run = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = PS2_EXT;
        2, 3:    b = PS2_BRK;
        4:       b = 8'h1C;
        5:       b = 8'h1D;
        6:       b = 8'h75;
        default: b = 8'($urandom_range(0, 255));
      endcase
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      pe0 = pe_cycles;
      if (kind == 0) model_byte(b);
      send_bits(frame_bits(b, kind), 11);
      check($sformatf("r%0d_parity_err_cycles", i), pe_cycles - pe0, (kind != 0) ? 1 : 0);
      check($sformatf("r%0d_key_count", i), key_count, m_count & 32'hFF);
      check($sformatf("r%0d_key_held", i), key_held, m_held);
      check($sformatf("r%0d_cur", i), {cur_ext, cur_code}, {m_ext, m_code});
    end
    rand_run  = 1'b0;
    wait_cyc(1);
    out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) wait_cyc(1);
    check("rand_all_delivered", exp_q.size(), 0);
    check("rand_fifo_empty", out_valid, 1'b0);
    check("rand_overflow", overflow, 1'b0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
